// File: rtl/frbus_wb_arb.sv
// FPU result-bus writeback arbiter: grants one source per cycle, registers the FP RF write, and accumulates sticky fflags.
// Optional macro FRBUS_RR_ARB_EN selects round-robin arbitration; the default is fixed priority with source 0 highest.
module frbus_wb_arb #(
   parameter int unsigned NUM_SRC = 3,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                        forever_cpuclk,
   input  logic                        cpurst_b,
   input  logic [NUM_SRC-1:0]          src_wb_vld,
   input  logic [NUM_SRC*DATA_W-1:0]   src_wb_data,
   input  logic [NUM_SRC*5-1:0]        src_wb_fflags,
   input  logic [NUM_SRC*5-1:0]        src_wb_freg,
   output logic [NUM_SRC-1:0]          src_wb_grant,
   input  logic                        rtu_yy_xx_flush,
   input  logic                        rtu_yy_xx_async_flush,
   input  logic                        rf_wb_stall,
   output logic                        frbus_rf_wen,
   output logic [4:0]                  frbus_rf_waddr,
   output logic [DATA_W-1:0]           frbus_rf_wdata,
   output logic [4:0]                  frbus_fflags_sticky,
   input  logic                        cp0_fflags_clr,
   output logic                        frbus_idle
);

   localparam int unsigned FLG_W = 5;
   localparam int unsigned REG_W = 5;

   logic                block_c;
   logic                xfer_c;
   logic [NUM_SRC-1:0]  grant_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic [FLG_W-1:0]    sel_flags_c;
   logic [REG_W-1:0]    sel_freg_c;

   assign block_c = rf_wb_stall | rtu_yy_xx_flush | rtu_yy_xx_async_flush;

`ifdef FRBUS_RR_ARB_EN
   localparam int unsigned PTR_W = $clog2(NUM_SRC);

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] gnt_idx_c;

   // Two-pass search: sources at or above the pointer first, then wrap to the lowest index.
   always_comb begin
      logic found;
      grant_c = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (!found && src_wb_vld[i] && (PTR_W'(i) >= ptr)) begin
            grant_c[i] = 1'b1;
            found      = 1'b1;
         end
      end
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (!found && src_wb_vld[i]) begin
            grant_c[i] = 1'b1;
            found      = 1'b1;
         end
      end
      if (block_c || !cpurst_b) grant_c = '0;
   end

   always_comb begin
      gnt_idx_c = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (grant_c[i]) gnt_idx_c = PTR_W'(i);
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ptr <= '0;
      end else if (xfer_c) begin
         ptr <= (gnt_idx_c == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
      end
   end
`else
   // Fixed priority: lowest index wins.
   always_comb begin
      logic found;
      grant_c = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (!found && src_wb_vld[i]) begin
            grant_c[i] = 1'b1;
            found      = 1'b1;
         end
      end
      if (block_c || !cpurst_b) grant_c = '0;
   end
`endif

   assign src_wb_grant = grant_c;
   assign xfer_c       = |grant_c;

   // One-hot AND-OR select of the granted source's payload; all zero when nothing is granted.
   always_comb begin
      sel_data_c  = '0;
      sel_flags_c = '0;
      sel_freg_c  = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         if (grant_c[i]) begin
            sel_data_c  = sel_data_c  | src_wb_data[i*DATA_W +: DATA_W];
            sel_flags_c = sel_flags_c | src_wb_fflags[i*FLG_W +: FLG_W];
            sel_freg_c  = sel_freg_c  | src_wb_freg[i*REG_W +: REG_W];
         end
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         frbus_rf_wen   <= 1'b0;
         frbus_rf_waddr <= '0;
         frbus_rf_wdata <= '0;
      end else begin
         frbus_rf_wen <= xfer_c;
         if (xfer_c) begin
            frbus_rf_waddr <= sel_freg_c;
            frbus_rf_wdata <= sel_data_c;
         end
      end
   end

   // A clear keeps a same-cycle transfer's flags; sel_flags_c is zero without a transfer.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         frbus_fflags_sticky <= '0;
      end else if (cp0_fflags_clr) begin
         frbus_fflags_sticky <= sel_flags_c;
      end else begin
         frbus_fflags_sticky <= frbus_fflags_sticky | sel_flags_c;
      end
   end

   assign frbus_idle = ~|src_wb_vld & ~frbus_rf_wen;

endmodule

// File: tb/tb_frbus_wb_arb.sv
// Self-checking bench for frbus_wb_arb: vector table plus scoreboard, with hand sequences for reset and contention.
module tb_frbus_wb_arb;

   localparam int unsigned NS = 3;
   localparam int unsigned DW = 32;

   logic            clk;
   logic            rst_n;
   logic [NS-1:0]   vld;
   logic [NS*DW-1:0] data;
   logic [NS*5-1:0] fflags;
   logic [NS*5-1:0] freg;
   logic [NS-1:0]   grant;
   logic            flush, aflush, stall, clr;
   logic            wen;
   logic [4:0]      waddr;
   logic [DW-1:0]   wdata;
   logic [4:0]      sticky;
   logic            idle;

   frbus_wb_arb #(.NUM_SRC(NS), .DATA_W(DW)) dut (
      .forever_cpuclk        (clk),
      .cpurst_b              (rst_n),
      .src_wb_vld            (vld),
      .src_wb_data           (data),
      .src_wb_fflags         (fflags),
      .src_wb_freg           (freg),
      .src_wb_grant          (grant),
      .rtu_yy_xx_flush       (flush),
      .rtu_yy_xx_async_flush (aflush),
      .rf_wb_stall           (stall),
      .frbus_rf_wen          (wen),
      .frbus_rf_waddr        (waddr),
      .frbus_rf_wdata        (wdata),
      .frbus_fflags_sticky   (sticky),
      .cp0_fflags_clr        (clr),
      .frbus_idle            (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NS-1:0] vld;
      logic          stall;
      logic          flush;
      logic          aflush;
      logic          clr;
      logic [4:0]    fl;
      logic [31:0]   d;
      logic [NS-1:0] eg;
   } vec_t;

   typedef struct {
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wr_t;

   int   checks   = 0;
   int   failures = 0;
   wr_t  sb_q[$];
   logic [4:0] sticky_m = '0;
   logic prev_wen = 1'b0;
   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Source s carries data d+s, destination register 7+s, and flags fl.
   task automatic drive_src(input logic [NS-1:0] v, input logic [4:0] fl, input logic [31:0] d);
      vld = v;
      for (int s = 0; s < int'(NS); s++) begin
         data[s*DW +: DW] = d + 32'(s);
         freg[s*5 +: 5]   = 5'(7 + s);
         fflags[s*5 +: 5] = fl;
      end
   endtask

   // One cycle: drive mid-cycle, check grant, push expected write, check registered outputs after the edge.
   task automatic step(input vec_t v, input string tag);
      wr_t w;
      logic exp_wen;
      @(negedge clk);
      drive_src(v.vld, v.fl, v.d);
      stall  = v.stall;
      flush  = v.flush;
      aflush = v.aflush;
      clr    = v.clr;
      #1;
      chk({tag, "_grant"}, 32'(grant), 32'(v.eg));
      chk({tag, "_wen_hold"}, 32'(wen), 32'(prev_wen));
      if (v.clr) sticky_m = '0;
      for (int s = 0; s < int'(NS); s++) begin
         if (v.eg[s]) begin
            w.waddr = 5'(7 + s);
            w.wdata = v.d + 32'(s);
            sb_q.push_back(w);
            sticky_m = sticky_m | v.fl;
         end
      end
      @(posedge clk);
      #1;
      exp_wen = (sb_q.size() > 0);
      chk({tag, "_wen"}, 32'(wen), 32'(exp_wen));
      if (exp_wen) begin
         w = sb_q.pop_front();
         chk({tag, "_waddr"}, 32'(waddr), 32'(w.waddr));
         chk({tag, "_wdata"}, wdata, w.wdata);
      end
      chk({tag, "_sticky"}, 32'(sticky), 32'(sticky_m));
      chk({tag, "_idle"}, 32'(idle), 32'((v.vld == '0) && !exp_wen));
      prev_wen = exp_wen;
   endtask

   function automatic vec_t mk(input logic [NS-1:0] v, input logic st, input logic fl_s,
                               input logic afl, input logic c, input logic [4:0] f,
                               input logic [31:0] d, input logic [NS-1:0] eg);
      vec_t r;
      r.vld = v; r.stall = st; r.flush = fl_s; r.aflush = afl; r.clr = c;
      r.fl = f; r.d = d; r.eg = eg;
      return r;
   endfunction

   initial begin
      rst_n = 1'b0;
      drive_src('0, '0, '0);
      stall = 0; flush = 0; aflush = 0; clr = 0;

      vt[0]  = mk(3'b000, 0, 0, 0, 0, 5'b00000, 32'h0000_0000, 3'b000);
      vt[1]  = mk(3'b001, 0, 0, 0, 0, 5'b00001, 32'h3F80_0000, 3'b001);
      vt[2]  = mk(3'b010, 1, 0, 0, 0, 5'b00010, 32'h4000_0000, 3'b000);
      vt[3]  = mk(3'b010, 1, 0, 0, 0, 5'b00010, 32'h4000_0000, 3'b000);
      vt[4]  = mk(3'b010, 1, 0, 0, 0, 5'b00010, 32'h4000_0000, 3'b000);
      vt[5]  = mk(3'b010, 0, 0, 0, 0, 5'b00010, 32'h4000_0000, 3'b010);
      vt[6]  = mk(3'b100, 0, 0, 0, 0, 5'b01000, 32'hC0A0_0000, 3'b100);
      vt[7]  = mk(3'b010, 0, 1, 0, 0, 5'b10000, 32'h1234_5678, 3'b000);
      vt[8]  = mk(3'b010, 0, 0, 1, 0, 5'b10000, 32'h1234_5678, 3'b000);
      vt[9]  = mk(3'b000, 0, 0, 0, 1, 5'b00000, 32'h0000_0000, 3'b000);
      vt[10] = mk(3'b100, 0, 0, 0, 0, 5'b10000, 32'hDEAD_BEE0, 3'b100);
      vt[11] = mk(3'b010, 0, 0, 0, 1, 5'b00100, 32'hCAFE_0000, 3'b010);
      vt[12] = mk(3'b001, 0, 0, 0, 0, 5'b00010, 32'h5555_AAAA, 3'b001);
      vt[13] = mk(3'b000, 0, 0, 0, 0, 5'b00000, 32'h0000_0000, 3'b000);

      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_sticky", 32'(sticky), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 14; k++) step(vt[k], $sformatf("v%0d", k));

      // Reset arrives while a write is registered and a request is still held.
      step(mk(3'b001, 0, 0, 0, 0, 5'b00100, 32'h0BAD_F00D, 3'b001), "rs_xfer");
      @(negedge clk);
      drive_src(3'b001, 5'b00100, 32'h0BAD_F00D);
      rst_n = 1'b0;
      #1;
      chk("rs_wen_now", 32'(wen), 32'd0);
      chk("rs_sticky_now", 32'(sticky), 32'd0);
      chk("rs_grant_now", 32'(grant), 32'd0);
      @(posedge clk); #1;
      chk("rs_wen_held", 32'(wen), 32'd0);
      @(negedge clk);
      drive_src('0, '0, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rs_wen_after", 32'(wen), 32'd0);
      chk("rs_idle_after", 32'(idle), 32'd1);
      sticky_m = '0;
      prev_wen = 1'b0;
      sb_q.delete();

      // Contention straight after reset, so the round-robin pointer starts at 0.
`ifdef FRBUS_RR_ARB_EN
      step(mk(3'b111, 0, 0, 0, 0, 5'b00001, 32'hA000_0000, 3'b001), "rr0");
      step(mk(3'b111, 0, 0, 0, 0, 5'b00010, 32'hB000_0000, 3'b010), "rr1");
      step(mk(3'b111, 0, 0, 0, 0, 5'b00100, 32'hC000_0000, 3'b100), "rr2");
      step(mk(3'b111, 0, 0, 0, 0, 5'b01000, 32'hD000_0000, 3'b001), "rr3");
`else
      step(mk(3'b101, 0, 0, 0, 0, 5'b00001, 32'hA000_0000, 3'b001), "fp0");
      step(mk(3'b100, 0, 0, 0, 0, 5'b01000, 32'hA000_0000, 3'b100), "fp1");
`endif
      step(mk(3'b000, 0, 0, 0, 0, 5'b00000, 32'h0000_0000, 3'b000), "end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
